// File: rtl/sram_1rw1r_param.sv
// Dual-port SRAM: port 0 is read/write with per-lane write mask, port 1 is read-only.
// Optional output register stage and optional write-to-read forwarding on port 1.
module sram_1rw1r_param #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int WMASK_W = 4,
    parameter int OUT_REG = 0,
    parameter int FORWARD = 1
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               csb0,
    input  logic               web0,
    input  logic [WMASK_W-1:0] wmask0,
    input  logic [ADDR_W-1:0]  addr0,
    input  logic [DATA_W-1:0]  din0,
    output logic [DATA_W-1:0]  dout0,
    output logic               rvalid0,
    input  logic               csb1,
    input  logic [ADDR_W-1:0]  addr1,
    output logic [DATA_W-1:0]  dout1,
    output logic               rvalid1
);

    localparam int LANE_W = DATA_W / WMASK_W;
    localparam int DEPTH  = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_en;
    logic              rd0_en;
    logic              rd1_en;
    logic [DATA_W-1:0] bit_mask;
    logic [DATA_W-1:0] rd1_word;

    // Accesses are refused while reset is held so reset never disturbs the array.
    assign wr_en  = !csb0 && !web0 && arst_n;
    assign rd0_en = !csb0 && web0;
    assign rd1_en = !csb1;

    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < WMASK_W; i++) begin
            bit_mask[i*LANE_W +: LANE_W] = {LANE_W{wmask0[i]}};
        end
    end

    // NOTE: the array has no reset; resetting it would turn the SRAM into flops.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < WMASK_W; i++) begin
                if (wmask0[i]) begin
                    mem[addr0][i*LANE_W +: LANE_W] <= din0[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_comb begin
        rd1_word = mem[addr1];
        if (FORWARD != 0 && wr_en && addr0 == addr1) begin
            rd1_word = (rd1_word & ~bit_mask) | (din0 & bit_mask);
        end
    end

    logic [DATA_W-1:0] s1_data0;
    logic [DATA_W-1:0] s1_data1;
    logic              s1_valid0;
    logic              s1_valid1;

    // Data registers load only on reads so idle and write cycles hold the last value.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s1_data0  <= '0;
            s1_data1  <= '0;
            s1_valid0 <= 1'b0;
            s1_valid1 <= 1'b0;
        end else begin
            s1_valid0 <= rd0_en;
            s1_valid1 <= rd1_en;
            if (rd0_en) s1_data0 <= mem[addr0];
            if (rd1_en) s1_data1 <= rd1_word;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] s2_data0;
            logic [DATA_W-1:0] s2_data1;
            logic              s2_valid0;
            logic              s2_valid1;

            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n) begin
                    s2_data0  <= '0;
                    s2_data1  <= '0;
                    s2_valid0 <= 1'b0;
                    s2_valid1 <= 1'b0;
                end else begin
                    s2_valid0 <= s1_valid0;
                    s2_valid1 <= s1_valid1;
                    if (s1_valid0) s2_data0 <= s1_data0;
                    if (s1_valid1) s2_data1 <= s1_data1;
                end
            end

            assign dout0   = s2_data0;
            assign rvalid0 = s2_valid0;
            assign dout1   = s2_data1;
            assign rvalid1 = s2_valid1;
        end else begin : g_no_out_reg
            assign dout0   = s1_data0;
            assign rvalid0 = s1_valid0;
            assign dout1   = s1_data1;
            assign rvalid1 = s1_valid1;
        end
    endgenerate

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Directed bench for sram_1rw1r_param: four instances cover OUT_REG 0/1, FORWARD 0/1,
// and the 32-bit default and 64-bit/6-bit/8-lane shapes, all driven by one stimulus stream.
module tb_sram_1rw1r_param;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        csb0;
    logic        web0;
    logic [7:0]  wmask0;
    logic [9:0]  addr0;
    logic [63:0] din0;
    logic        csb1;
    logic [9:0]  addr1;

    logic [31:0] dout0_a, dout1_a, dout0_b, dout1_b;
    logic [63:0] dout0_c, dout1_c, dout0_d, dout1_d;
    logic        rvalid0_a, rvalid1_a, rvalid0_b, rvalid1_b;
    logic        rvalid0_c, rvalid1_c, rvalid0_d, rvalid1_d;

    int passed = 0;
    int total  = 0;

    // Instance order: a (32b, lat 1, fwd), b (32b, lat 2, no fwd), c (64b, lat 2, fwd), d (64b, lat 1, no fwd)
    localparam int          LAT   [4] = '{1, 2, 2, 1};
    localparam bit          FWD   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [63:0] DMASK [4] = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF,
                                          64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};

    logic [63:0] d0 [4];
    logic [63:0] d1 [4];
    logic        v0 [4];
    logic        v1 [4];

    assign d0[0] = {32'h0, dout0_a};
    assign d1[0] = {32'h0, dout1_a};
    assign d0[1] = {32'h0, dout0_b};
    assign d1[1] = {32'h0, dout1_b};
    assign d0[2] = dout0_c;
    assign d1[2] = dout1_c;
    assign d0[3] = dout0_d;
    assign d1[3] = dout1_d;
    assign v0[0] = rvalid0_a;
    assign v1[0] = rvalid1_a;
    assign v0[1] = rvalid0_b;
    assign v1[1] = rvalid1_b;
    assign v0[2] = rvalid0_c;
    assign v1[2] = rvalid1_c;
    assign v0[3] = rvalid0_d;
    assign v1[3] = rvalid1_d;

    always #5 clk = ~clk;

    sram_1rw1r_param #(.DATA_W(32), .ADDR_W(10), .WMASK_W(4), .OUT_REG(0), .FORWARD(1)) dut_a (
        .clk(clk), .arst_n(arst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0[3:0]),
        .addr0(addr0), .din0(din0[31:0]), .dout0(dout0_a), .rvalid0(rvalid0_a),
        .csb1(csb1), .addr1(addr1), .dout1(dout1_a), .rvalid1(rvalid1_a));

    sram_1rw1r_param #(.DATA_W(32), .ADDR_W(10), .WMASK_W(4), .OUT_REG(1), .FORWARD(0)) dut_b (
        .clk(clk), .arst_n(arst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0[3:0]),
        .addr0(addr0), .din0(din0[31:0]), .dout0(dout0_b), .rvalid0(rvalid0_b),
        .csb1(csb1), .addr1(addr1), .dout1(dout1_b), .rvalid1(rvalid1_b));

    sram_1rw1r_param #(.DATA_W(64), .ADDR_W(6), .WMASK_W(8), .OUT_REG(1), .FORWARD(1)) dut_c (
        .clk(clk), .arst_n(arst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0),
        .addr0(addr0[5:0]), .din0(din0), .dout0(dout0_c), .rvalid0(rvalid0_c),
        .csb1(csb1), .addr1(addr1[5:0]), .dout1(dout1_c), .rvalid1(rvalid1_c));

    sram_1rw1r_param #(.DATA_W(64), .ADDR_W(6), .WMASK_W(8), .OUT_REG(0), .FORWARD(0)) dut_d (
        .clk(clk), .arst_n(arst_n), .csb0(csb0), .web0(web0), .wmask0(wmask0),
        .addr0(addr0[5:0]), .din0(din0), .dout0(dout0_d), .rvalid0(rvalid0_d),
        .csb1(csb1), .addr1(addr1[5:0]), .dout1(dout1_d), .rvalid1(rvalid1_d));

    task automatic drive(input logic c0, input logic w0, input logic [7:0] m, input logic [9:0] a0,
                         input logic [63:0] d, input logic c1, input logic [9:0] a1);
        csb0   = c0;
        web0   = w0;
        wmask0 = m;
        addr0  = a0;
        din0   = d;
        csb1   = c1;
        addr1  = a1;
    endtask

    task automatic drive_idle();
        drive(1'b1, 1'b1, 8'h00, 10'd0, 64'h0, 1'b1, 10'd0);
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            total++; if (d0[i] !== 64'h0) $display("FAIL reset dout0 dut%0d: got %h want 0", i, d0[i]); else passed++;
            total++; if (d1[i] !== 64'h0) $display("FAIL reset dout1 dut%0d: got %h want 0", i, d1[i]); else passed++;
            total++; if (v0[i] !== 1'b0) $display("FAIL reset rvalid0 dut%0d: got %b want 0", i, v0[i]); else passed++;
            total++; if (v1[i] !== 1'b0) $display("FAIL reset rvalid1 dut%0d: got %b want 0", i, v1[i]); else passed++;
        end
        arst_n = 1'b1;
    endtask

    // Full write to addr 5, read it back; the write cycle must leave dout0/rvalid0 alone.
    task automatic test_full_write();
        for (int j = 0; j < 4; j++) begin
            if (j == 0) drive(1'b0, 1'b0, 8'hFF, 10'd5, 64'hCAFEF00D_DEADBEEF, 1'b1, 10'd0);
            else if (j == 1) drive(1'b0, 1'b1, 8'h00, 10'd5, 64'h0, 1'b1, 10'd0);
            else drive_idle();
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                int          idx;
                logic [63:0] e;
                idx = j + 1 - LAT[i];
                e   = (idx >= 1) ? (64'hCAFEF00D_DEADBEEF & DMASK[i]) : 64'h0;
                total++; if (v0[i] !== (idx == 1)) $display("FAIL full_write rvalid0 dut%0d cyc%0d: got %b want %b", i, j, v0[i], idx == 1); else passed++;
                total++; if (d0[i] !== e) $display("FAIL full_write dout0 dut%0d cyc%0d: got %h want %h", i, j, d0[i], e); else passed++;
                total++; if (v1[i] !== 1'b0) $display("FAIL full_write rvalid1 dut%0d cyc%0d: got %b want 0", i, j, v1[i]); else passed++;
            end
        end
    endtask

    // Full write, masked write, empty-mask write, then both ports read addr 7 the next cycle.
    task automatic test_masked_write();
        for (int j = 0; j < 6; j++) begin
            case (j)
                0: drive(1'b0, 1'b0, 8'hFF, 10'd7, 64'h55667788_11223344, 1'b1, 10'd0);
                1: drive(1'b0, 1'b0, 8'h35, 10'd7, 64'h99887766_AABBCCDD, 1'b1, 10'd0);
                2: drive(1'b0, 1'b0, 8'h00, 10'd7, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 10'd0);
                3: drive(1'b0, 1'b1, 8'h00, 10'd7, 64'h0, 1'b0, 10'd7);
                default: drive_idle();
            endcase
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                int          idx;
                logic [63:0] e0;
                logic [63:0] e1;
                idx = j + 1 - LAT[i];
                e0  = (idx >= 3) ? (64'h55667766_11BB33DD & DMASK[i]) : (64'hCAFEF00D_DEADBEEF & DMASK[i]);
                e1  = (idx >= 3) ? (64'h55667766_11BB33DD & DMASK[i]) : 64'h0;
                total++; if (v0[i] !== (idx == 3)) $display("FAIL masked rvalid0 dut%0d cyc%0d: got %b want %b", i, j, v0[i], idx == 3); else passed++;
                total++; if (d0[i] !== e0) $display("FAIL masked dout0 dut%0d cyc%0d: got %h want %h", i, j, d0[i], e0); else passed++;
                total++; if (v1[i] !== (idx == 3)) $display("FAIL masked rvalid1 dut%0d cyc%0d: got %b want %b", i, j, v1[i], idx == 3); else passed++;
                total++; if (d1[i] !== e1) $display("FAIL masked dout1 dut%0d cyc%0d: got %h want %h", i, j, d1[i], e1); else passed++;
            end
        end
    endtask

    // Same-address write/read collisions on addr 9, full then partial mask, then port 0 read-back.
    task automatic test_collision();
        for (int j = 0; j < 6; j++) begin
            case (j)
                0: drive(1'b0, 1'b0, 8'hFF, 10'd9, 64'h0, 1'b1, 10'd0);
                1: drive(1'b0, 1'b0, 8'hFF, 10'd9, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 10'd9);
                2: drive(1'b0, 1'b0, 8'h5A, 10'd9, 64'h12345678_9ABCDEF0, 1'b0, 10'd9);
                3: drive(1'b0, 1'b1, 8'h00, 10'd9, 64'h0, 1'b1, 10'd0);
                default: drive_idle();
            endcase
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                int          idx;
                logic [63:0] e1;
                logic [63:0] e0;
                idx = j + 1 - LAT[i];
                if (idx == 1) e1 = FWD[i] ? 64'hFFFFFFFF_FFFFFFFF : 64'h0;
                else          e1 = FWD[i] ? 64'hFF34FF78_9AFFDEFF : 64'hFFFFFFFF_FFFFFFFF;
                e1 = e1 & DMASK[i];
                e0 = 64'hFF34FF78_9AFFDEFF & DMASK[i];
                total++; if (v1[i] !== (idx == 1 || idx == 2)) $display("FAIL collision rvalid1 dut%0d cyc%0d: got %b want %b", i, j, v1[i], idx == 1 || idx == 2); else passed++;
                if (idx == 1 || idx == 2) begin
                    total++; if (d1[i] !== e1) $display("FAIL collision dout1 dut%0d cyc%0d: got %h want %h", i, j, d1[i], e1); else passed++;
                end
                total++; if (v0[i] !== (idx == 3)) $display("FAIL collision rvalid0 dut%0d cyc%0d: got %b want %b", i, j, v0[i], idx == 3); else passed++;
                if (idx == 3) begin
                    total++; if (d0[i] !== e0) $display("FAIL collision dout0 dut%0d cyc%0d: got %h want %h", i, j, d0[i], e0); else passed++;
                end
            end
        end
    endtask

    // Reset lands while a read is in flight; outputs clear at once and the read never surfaces.
    task automatic test_reset_inflight();
        drive(1'b0, 1'b1, 8'h00, 10'd7, 64'h0, 1'b0, 10'd7);
        @(posedge clk);
        #1;
        arst_n = 1'b0;
        drive_idle();
        #1;
        for (int i = 0; i < 4; i++) begin
            total++; if (d0[i] !== 64'h0) $display("FAIL inflight dout0 dut%0d: got %h want 0", i, d0[i]); else passed++;
            total++; if (d1[i] !== 64'h0) $display("FAIL inflight dout1 dut%0d: got %h want 0", i, d1[i]); else passed++;
            total++; if (v0[i] !== 1'b0) $display("FAIL inflight rvalid0 dut%0d: got %b want 0", i, v0[i]); else passed++;
            total++; if (v1[i] !== 1'b0) $display("FAIL inflight rvalid1 dut%0d: got %b want 0", i, v1[i]); else passed++;
        end
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                total++; if (v0[i] !== 1'b0) $display("FAIL post_reset rvalid0 dut%0d cyc%0d: got %b want 0", i, j, v0[i]); else passed++;
                total++; if (v1[i] !== 1'b0) $display("FAIL post_reset rvalid1 dut%0d cyc%0d: got %b want 0", i, j, v1[i]); else passed++;
            end
        end
        for (int j = 0; j < 3; j++) begin
            if (j == 0) drive(1'b0, 1'b1, 8'h00, 10'd5, 64'h0, 1'b0, 10'd9);
            else drive_idle();
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                int          idx;
                logic [63:0] e0;
                logic [63:0] e1;
                idx = j + 1 - LAT[i];
                e0  = (idx >= 0) ? (64'hCAFEF00D_DEADBEEF & DMASK[i]) : 64'h0;
                e1  = (idx >= 0) ? (64'hFF34FF78_9AFFDEFF & DMASK[i]) : 64'h0;
                total++; if (v0[i] !== (idx == 0)) $display("FAIL retained rvalid0 dut%0d cyc%0d: got %b want %b", i, j, v0[i], idx == 0); else passed++;
                total++; if (d0[i] !== e0) $display("FAIL retained dout0 dut%0d cyc%0d: got %h want %h", i, j, d0[i], e0); else passed++;
                total++; if (v1[i] !== (idx == 0)) $display("FAIL retained rvalid1 dut%0d cyc%0d: got %b want %b", i, j, v1[i], idx == 0); else passed++;
                total++; if (d1[i] !== e1) $display("FAIL retained dout1 dut%0d cyc%0d: got %h want %h", i, j, d1[i], e1); else passed++;
            end
        end
    endtask

    // Fill addr n with n, then stream reads every cycle: port 0 ascending, port 1 descending.
    task automatic test_back_to_back();
        for (int n = 0; n < 16; n++) begin
            drive(1'b0, 1'b0, 8'hFF, 10'(n), 64'(n), 1'b1, 10'd0);
            @(negedge clk);
        end
        for (int j = 0; j < 18; j++) begin
            if (j < 16) drive(1'b0, 1'b1, 8'h00, 10'(j), 64'h0, 1'b0, 10'(15 - j));
            else drive_idle();
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                int idx;
                bit live;
                idx  = j + 1 - LAT[i];
                live = (idx >= 0 && idx < 16);
                total++; if (v0[i] !== live) $display("FAIL stream rvalid0 dut%0d cyc%0d: got %b want %b", i, j, v0[i], live); else passed++;
                total++; if (v1[i] !== live) $display("FAIL stream rvalid1 dut%0d cyc%0d: got %b want %b", i, j, v1[i], live); else passed++;
                if (live) begin
                    total++; if (d0[i] !== 64'(idx)) $display("FAIL stream dout0 dut%0d cyc%0d: got %h want %h", i, j, d0[i], 64'(idx)); else passed++;
                    total++; if (d1[i] !== 64'(15 - idx)) $display("FAIL stream dout1 dut%0d cyc%0d: got %h want %h", i, j, d1[i], 64'(15 - idx)); else passed++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_masked_write();
        test_collision();
        test_reset_inflight();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
